// File: rtl/commit_writeback_if.sv
// Step-descriptor bus between the operand decoder (master) and the commit/writeback stage (slave).
// Carries two destination descriptors, the post-step EIP and the trace's two memory-write hints.
interface commit_writeback_if;
  logic        step_valid;
  logic        step_ready;
  logic [1:0]  dest0_kind;
  logic [31:0] dest0_sel;
  logic [1:0]  dest0_size;
  logic [31:0] dest0_val;
  logic [1:0]  dest1_kind;
  logic [31:0] dest1_sel;
  logic [1:0]  dest1_size;
  logic [31:0] dest1_val;
  logic [31:0] next_eip;
  logic        hint1_is_write;
  logic [31:0] hint1_address;
  logic [31:0] hint1_data;
  logic        hint2_is_write;
  logic [31:0] hint2_address;
  logic [31:0] hint2_data;

  modport master (
    output step_valid, dest0_kind, dest0_sel, dest0_size, dest0_val,
           dest1_kind, dest1_sel, dest1_size, dest1_val, next_eip,
           hint1_is_write, hint1_address, hint1_data,
           hint2_is_write, hint2_address, hint2_data,
    input  step_ready
  );

  modport slave (
    input  step_valid, dest0_kind, dest0_sel, dest0_size, dest0_val,
           dest1_kind, dest1_sel, dest1_size, dest1_val, next_eip,
           hint1_is_write, hint1_address, hint1_data,
           hint2_is_write, hint2_address, hint2_data,
    output step_ready
  );
endinterface

// File: rtl/commit_writeback.sv
// Commit stage: applies up to two destinations per step to the 8-GPR file and EIP,
// checks memory destinations against trace write hints and halts on the first mismatch.
module commit_writeback #(
  parameter int STEP_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_valid,
  input  logic [255:0]        init_regs,
  input  logic [31:0]         init_eip,
  commit_writeback_if.slave   step,
  output logic [255:0]        regs,
  output logic [31:0]         eip,
  output logic [STEP_W-1:0]   step_count,
  output logic                commit_pulse,
  output logic                mismatch
);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_RUN  = 2'b01,
    S_D1   = 2'b10,
    S_HALT = 2'b11
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_REG  = 2'b01;
  localparam logic [1:0] KIND_MEM  = 2'b10;

  function automatic logic [31:0] size_mask(input logic [1:0] size);
    logic [31:0] m;
    case (size)
      2'b00:   m = 32'hFFFF_FFFF;
      2'b01:   m = 32'h0000_FFFF;
      2'b10:   m = 32'h0000_00FF;
      2'b11:   m = 32'h0000_00FF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // 8b-high targets AH/CH/DH/BH, so only sel[1:0] picks the register.
  function automatic logic [255:0] reg_apply(input logic [255:0] r, input logic [31:0] sel,
                                             input logic [1:0] size, input logic [31:0] val);
    logic [255:0] res;
    logic [31:0]  cur;
    logic [2:0]   idx;
    res = r;
    idx = (size == 2'b11) ? {1'b0, sel[1:0]} : sel[2:0];
    cur = r[{idx, 5'd0} +: 32];
    case (size)
      2'b00:   cur        = val;
      2'b01:   cur[15:0]  = val[15:0];
      2'b10:   cur[7:0]   = val[7:0];
      2'b11:   cur[15:8]  = val[7:0];
      default: cur        = val;
    endcase
    res[{idx, 5'd0} +: 32] = cur;
    return res;
  endfunction

  function automatic logic hint_match(input logic hw, input logic [31:0] ha, input logic [31:0] hd,
                                      input logic [31:0] sel, input logic [1:0] size,
                                      input logic [31:0] val);
    logic [31:0] m;
    m = size_mask(size);
    return hw && (ha == sel) && ((val & m) == (hd & m));
  endfunction

  state_t              state_r, state_nx;
  logic [255:0]        regs_r, regs_nx;
  logic [31:0]         eip_r, eip_nx;
  logic [STEP_W-1:0]   count_r, count_nx, count_inc_s;
  logic                pulse_r, pulse_nx;
  logic                mismatch_r, mismatch_nx;
  logic                step_ready_r;
  logic                latch_s, fire_s;

  logic [1:0]          d1_kind_r, d1_size_r;
  logic [31:0]         d1_sel_r, d1_val_r, neip_r;
  logic                h1_w_r, h2_w_r;
  logic [31:0]         h1_a_r, h1_d_r, h2_a_r, h2_d_r;

  logic [1:0]          cur_kind_s, cur_size_s;
  logic [31:0]         cur_sel_s, cur_val_s;
  logic                cur_h1w_s, cur_h2w_s;
  logic [31:0]         cur_h1a_s, cur_h1d_s, cur_h2a_s, cur_h2d_s;
  logic                cur_ok_s;
  logic [255:0]        regs_app_s;

  assign fire_s      = step.step_valid & step_ready_r;
  assign count_inc_s = (&count_r) ? count_r : (count_r + {{(STEP_W-1){1'b0}}, 1'b1});

  // Select the destination being retired this cycle: live dest0 in S_RUN, latched dest1 in S_D1.
  always_comb begin
    if (state_r == S_D1) begin
      cur_kind_s = d1_kind_r;
      cur_sel_s  = d1_sel_r;
      cur_size_s = d1_size_r;
      cur_val_s  = d1_val_r;
      cur_h1w_s  = h1_w_r;
      cur_h1a_s  = h1_a_r;
      cur_h1d_s  = h1_d_r;
      cur_h2w_s  = h2_w_r;
      cur_h2a_s  = h2_a_r;
      cur_h2d_s  = h2_d_r;
    end else begin
      cur_kind_s = step.dest0_kind;
      cur_sel_s  = step.dest0_sel;
      cur_size_s = step.dest0_size;
      cur_val_s  = step.dest0_val;
      cur_h1w_s  = step.hint1_is_write;
      cur_h1a_s  = step.hint1_address;
      cur_h1d_s  = step.hint1_data;
      cur_h2w_s  = step.hint2_is_write;
      cur_h2a_s  = step.hint2_address;
      cur_h2d_s  = step.hint2_data;
    end
  end

  // Evaluate the selected destination: register update and memory cross-check.
  always_comb begin
    regs_app_s = regs_r;
    cur_ok_s   = 1'b0;
    case (cur_kind_s)
      KIND_NONE: cur_ok_s = 1'b1;
      KIND_REG: begin
        cur_ok_s   = 1'b1;
        regs_app_s = reg_apply(regs_r, cur_sel_s, cur_size_s, cur_val_s);
      end
      KIND_MEM: cur_ok_s =
          hint_match(cur_h1w_s, cur_h1a_s, cur_h1d_s, cur_sel_s, cur_size_s, cur_val_s) |
          hint_match(cur_h2w_s, cur_h2a_s, cur_h2d_s, cur_sel_s, cur_size_s, cur_val_s);
      default:  cur_ok_s = 1'b0;
    endcase
  end

  // Next-state and architectural update logic.
  always_comb begin
    state_nx    = state_r;
    regs_nx     = regs_r;
    eip_nx      = eip_r;
    count_nx    = count_r;
    pulse_nx    = 1'b0;
    mismatch_nx = mismatch_r;
    latch_s     = 1'b0;
    case (state_r)
      S_INIT: begin
        if (init_valid) begin
          regs_nx  = init_regs;
          eip_nx   = init_eip;
          state_nx = S_RUN;
        end else begin
          state_nx = S_INIT;
        end
      end
      S_RUN: begin
        if (fire_s) begin
          if (cur_ok_s) begin
            regs_nx = regs_app_s;
            latch_s = 1'b1;
            if (step.dest1_kind == KIND_NONE) begin
              eip_nx   = step.next_eip;
              count_nx = count_inc_s;
              pulse_nx = 1'b1;
            end else begin
              state_nx = S_D1;
            end
          end else begin
            mismatch_nx = 1'b1;
            state_nx    = S_HALT;
          end
        end else begin
          state_nx = S_RUN;
        end
      end
      S_D1: begin
        if (cur_ok_s) begin
          regs_nx  = regs_app_s;
          eip_nx   = neip_r;
          count_nx = count_inc_s;
          pulse_nx = 1'b1;
          state_nx = S_RUN;
        end else begin
          mismatch_nx = 1'b1;
          state_nx    = S_HALT;
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_INIT;
    endcase
  end

  // State, architectural registers and dest1/hint holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_INIT;
      regs_r       <= 256'd0;
      eip_r        <= 32'd0;
      count_r      <= {STEP_W{1'b0}};
      pulse_r      <= 1'b0;
      mismatch_r   <= 1'b0;
      step_ready_r <= 1'b0;
      d1_kind_r    <= 2'b00;
      d1_sel_r     <= 32'd0;
      d1_size_r    <= 2'b00;
      d1_val_r     <= 32'd0;
      neip_r       <= 32'd0;
      h1_w_r       <= 1'b0;
      h1_a_r       <= 32'd0;
      h1_d_r       <= 32'd0;
      h2_w_r       <= 1'b0;
      h2_a_r       <= 32'd0;
      h2_d_r       <= 32'd0;
    end else begin
      state_r      <= state_nx;
      regs_r       <= regs_nx;
      eip_r        <= eip_nx;
      count_r      <= count_nx;
      pulse_r      <= pulse_nx;
      mismatch_r   <= mismatch_nx;
      step_ready_r <= (state_nx == S_RUN);
      if (latch_s) begin
        d1_kind_r <= step.dest1_kind;
        d1_sel_r  <= step.dest1_sel;
        d1_size_r <= step.dest1_size;
        d1_val_r  <= step.dest1_val;
        neip_r    <= step.next_eip;
        h1_w_r    <= step.hint1_is_write;
        h1_a_r    <= step.hint1_address;
        h1_d_r    <= step.hint1_data;
        h2_w_r    <= step.hint2_is_write;
        h2_a_r    <= step.hint2_address;
        h2_d_r    <= step.hint2_data;
      end
    end
  end

  assign step.step_ready = step_ready_r;
  assign regs            = regs_r;
  assign eip             = eip_r;
  assign step_count      = count_r;
  assign commit_pulse    = pulse_r;
  assign mismatch        = mismatch_r;

endmodule
